// File: rtl/mdarray_pkg.sv
// Shared constants and state encoding for the mdarray scanner and its read-return FIFO.
package mdarray_pkg;

    localparam int W      = 2;
    localparam int IDX_W  = W + 1;
    localparam int ELEMS  = (W + 1) ** 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DUMP,
        DRAIN
    } scan_state_t;

endpackage

// File: rtl/mdarray_scanner_if.sv
// Stream and array-port bundle between the scanner (master side) and its environment (slave side).
interface mdarray_scanner_if
    import mdarray_pkg::*;
#(
    parameter int W = mdarray_pkg::W
) ();

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [W:0]        col;
    logic [W:0]        row;
    logic [W:0]        slc;
    logic              wr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        input  s_data, s_valid, mem_q, m_ready,
        output s_ready, col, row, slc, wr, mem_data, m_data, m_valid
    );

    modport slave (
        output s_data, s_valid, mem_q, m_ready,
        input  s_ready, col, row, slc, wr, mem_data, m_data, m_valid
    );

endinterface

// File: rtl/mdarray_rdfifo.sv
// Small synchronous FIFO that catches array read returns; occupancy is exported for credit control.
module mdarray_rdfifo
    import mdarray_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = mdarray_pkg::DATA_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clock) begin
        if (push) store[wr_ptr] <= push_data;
    end

    assign pop_data = store[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/mdarray_scanner.sv
// Raster sweep over the (W+1)^3 array: fills it from an input stream or dumps it to an output
// stream, hiding the array's fixed read latency behind a credit-limited return FIFO.
module mdarray_scanner
    import mdarray_pkg::*;
#(
    parameter int W          = mdarray_pkg::W,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    mdarray_scanner_if.master bus
);

    localparam int         CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [W:0] IDX_MAX = (W + 1)'(W);

    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [W:0]        col_q;
    logic [W:0]        row_q;
    logic [W:0]        slc_q;
    logic [RD_LAT-1:0] vld_sr;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              credit_ok;
    logic              at_last;
    logic              start_sweep;
    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;
    logic              done_set;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_sr[i]);
    end

    // A read may only go out if a FIFO slot is guaranteed for its return.
    assign credit_ok = (int'(inflight) + int'(fifo_count)) < FIFO_DEPTH;
    assign at_last   = (col_q == IDX_MAX) && (row_q == IDX_MAX) && (slc_q == IDX_MAX);
    assign push      = vld_sr[RD_LAT-1];
    assign pop       = !fifo_empty && bus.m_ready;

    always_comb begin
        state_nxt    = state;
        start_sweep  = 1'b0;
        accept       = 1'b0;
        issue        = 1'b0;
        done_set     = 1'b0;
        bus.s_ready  = 1'b0;
        bus.wr       = 1'b0;
        bus.mem_data = '0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    start_sweep = 1'b1;
                    state_nxt   = mode ? DUMP : FILL;
                end
            end
            FILL: begin
                bus.s_ready  = 1'b1;
                bus.wr       = bus.s_valid;
                bus.mem_data = bus.s_data;
                accept       = bus.s_valid;
                if (accept && at_last) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            DUMP: begin
                issue = credit_ok;
                if (issue && at_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight == '0 && (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_set;
        end
    end

    // Raster counter: col fastest, wrapping past the last element back to the origin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            slc_q <= '0;
        end else if (start_sweep) begin
            col_q <= '0;
            row_q <= '0;
            slc_q <= '0;
        end else if (accept || issue) begin
            if (col_q == IDX_MAX) begin
                col_q <= '0;
                if (row_q == IDX_MAX) begin
                    row_q <= '0;
                    slc_q <= (slc_q == IDX_MAX) ? '0 : slc_q + 1'b1;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    mdarray_rdfifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_rdfifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (bus.mem_q),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy        = (state != IDLE) || done;
    assign bus.col     = col_q;
    assign bus.row     = row_q;
    assign bus.slc     = slc_q;
    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = fifo_empty ? '0 : fifo_head;

endmodule
